// File: rtl/cdc_bus_arbiter_hs.sv
// cdc_bus_arbiter_hs
// Round-robin arbiter that shares one multi-bit CDC channel among NREQ
// din_clk-domain requesters. The winning word is parked in a quasi-static
// hold register and handed to the dout_clk domain with a toggle req/ack
// handshake. Only the two toggle flags cross through synchronizer chains;
// hold data/id are multicycle paths that are stable before they are captured.
module cdc_bus_arbiter_hs #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  din_clk,
  input  logic                  aclr,
  input  logic                  dout_clk,
  input  logic [NREQ-1:0]       src_valid,
  input  logic [NREQ*WIDTH-1:0] src_data,
  output logic [NREQ-1:0]       src_ready,
  output logic                  busy,
  output logic                  dout_valid,
  output logic [WIDTH-1:0]      dout_data,
  output logic [IDW-1:0]        dout_id
);

  localparam logic [0:0]     ST_IDLE     = 1'b0;
  localparam logic [0:0]     ST_WAIT_ACK = 1'b1;
  localparam logic [IDW-1:0] LAST_INIT   = IDW'(NREQ - 1);

  // ---------------- source domain (din_clk) ----------------
  logic [0:0]       r_state;
  logic [IDW-1:0]   r_last;
  logic             r_req_tgl;
  logic [WIDTH-1:0] r_hold_data;
  logic [IDW-1:0]   r_hold_id;

  (* ASYNC_REG = "TRUE", preserve = 1, dont_replicate = "true" *)
  logic             r_ack_meta;
  (* ASYNC_REG = "TRUE" *)
  logic             r_ack_sync;

  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic [IDW-1:0]   w_idx;
  logic [WIDTH-1:0] w_gdata;

  // ---------------- destination domain (dout_clk) ----------------
  (* ASYNC_REG = "TRUE", preserve = 1, dont_replicate = "true" *)
  logic             r_req_meta;
  (* ASYNC_REG = "TRUE" *)
  logic             r_req_sync;
  logic             r_req_prev;
  logic             r_ack_tgl;
  logic             r_dout_valid;
  logic [WIDTH-1:0] r_dout_data;
  logic [IDW-1:0]   r_dout_id;

  // Round-robin search: first valid requester at last+1, last+2, ... (mod NREQ)
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      w_idx = IDW'((32'(r_last) + off) % 32'(NREQ));
      if (!w_found && src_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Select the granted requester's word
  always_comb begin
    w_gdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_gdata = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept only while idle; busy whenever a word is in flight
  always_comb begin
    src_ready = '0;
    if (r_state == ST_IDLE && w_found) begin
      src_ready[w_grant] = 1'b1;
    end
    busy = (r_state == ST_WAIT_ACK);
  end

  // Bring the destination's ack toggle into din_clk
  always_ff @(posedge din_clk or posedge aclr) begin
    if (aclr) begin
      r_ack_meta <= 1'b0;
      r_ack_sync <= 1'b0;
    end else begin
      r_ack_meta <= r_ack_tgl;
      r_ack_sync <= r_ack_meta;
    end
  end

  // Source FSM: grant and capture in IDLE, hold until the ack toggle matches
  always_ff @(posedge din_clk or posedge aclr) begin
    if (aclr) begin
      r_state     <= ST_IDLE;
      r_last      <= LAST_INIT;
      r_req_tgl   <= 1'b0;
      r_hold_data <= '0;
      r_hold_id   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_hold_data <= w_gdata;
            r_hold_id   <= w_grant;
            r_last      <= w_grant;
            r_req_tgl   <= ~r_req_tgl;
            r_state     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (r_ack_sync == r_req_tgl) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bring the request toggle into dout_clk and keep a delayed copy for edge detect
  always_ff @(posedge dout_clk or posedge aclr) begin
    if (aclr) begin
      r_req_meta <= 1'b0;
      r_req_sync <= 1'b0;
      r_req_prev <= 1'b0;
    end else begin
      r_req_meta <= r_req_tgl;
      r_req_sync <= r_req_meta;
      r_req_prev <= r_req_sync;
    end
  end

  // On a request toggle edge: capture the held word, pulse valid, return the ack
  always_ff @(posedge dout_clk or posedge aclr) begin
    if (aclr) begin
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_dout_id    <= '0;
      r_ack_tgl    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (r_req_sync != r_req_prev) begin
        r_dout_data  <= r_hold_data;
        r_dout_id    <= r_hold_id;
        r_dout_valid <= 1'b1;
        r_ack_tgl    <= r_req_sync;
      end
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign dout_id    = r_dout_id;

endmodule
